grid_verifier: RTL and testbench
================================

Name: grid_verifier

Overview:
- Downstream consumer of the grid generator.
- Its start is driven by the generator's done level.
- Scans the finished grid in row-major order through a synchronous read port.
- Checks every cell for range, row, column and block uniqueness, and reports pass/fail plus the first offending cell and its class.

Parameters:
ORDER, 3, block side length; LENGTH = ORDER*ORDER values per row/col/block, AREA = LENGTH*LENGTH cells (derived in grid_pkg, not overridable)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low; low forces idle state immediately
start  in  1  level/pulse; sampled at rising edge when not busy
rd_en  out  1  read request to grid storage
rd_row  out  clog2(LENGTH)  row of requested cell
rd_col  out  clog2(LENGTH)  column of requested cell
rd_data  in  clog2(LENGTH+1)  cell value, valid the cycle after rd_en; 0 = empty
busy  out  1  scan in progress
done  out  1  level; high from scan end until next accepted start or reset
success  out  1  valid while done; 1 = grid legal
err_code  out  3  valid while done: 0 NONE, 1 RANGE, 2 ROW, 3 COL, 4 BLOCK
err_row  out  clog2(LENGTH)  offending cell row (optional feature)
err_col  out  clog2(LENGTH)  offending cell column (optional feature)

Behaviour:
- Reset (async, low): all outputs 0, state IDLE, all occupancy masks cleared.
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE/DONE + start=1 at edge E0 -> SCAN.
  - Clears done, success, err_* and all masks.
  - busy=1 after E0.
- start while busy: ignored.
- SCAN: rd_en=1; one address per cycle, rd_row/rd_col = 0,0 after E0, advancing column then row.
  - Address k is presented after edge E0+k.
  - rd_data for k is valid in the following cycle and is checked at edge E0+k+2.
- DRAIN: entered after the last address (8,8) is issued; rd_en=0; waits for the final check.
- Masks:
  - row mask: LENGTH bits, cleared at each row start.
  - column masks: LENGTH x LENGTH bits.
  - block masks: ORDER x LENGTH bits, cleared at each band start (row % ORDER == 0, col 0).
- Check priority per cell:
  - RANGE if value==0 or value>LENGTH.
  - else ROW if row-mask bit set.
  - else COL if column-mask bit set.
  - else BLOCK if block-mask bit set.
  - else set all three bits.
- First error, checked at edge E0+k+2:
  - -> DONE; done=1, success=0, err_code set, err location = cell k.
  - rd_en drops; any in-flight read is discarded.
- No error after cell AREA-1:
  - done=1, success=1, err_code=0 after edge E0+AREA+1 (82 cycles for ORDER=3).
  - busy=0.
- Reset mid-scan: immediate abort, done stays 0.
- start coincident with the final check edge: the check completes and done is raised; start is ignored (busy at that edge).

Optional Feature:
GRID_VERIFIER_ERR_LOC_EN
- Defined: err_row/err_col ports exist, registered with the first offending cell; hold 0 on success.
- Undefined: ports and their registers absent; err_code still reported.

Decomposition:
- grid_pkg holds:
  - ORDER, LENGTH, AREA
  - value_t (clog2(LENGTH+1) bits), index_t (clog2(LENGTH) bits)
  - err_code_e enum
  - function block_of(row, col)
- One natural sub-module: unit_mask.
  - LENGTH-bit occupancy register with clear, set(value) and hit(value) outputs.
  - Instantiated for the row, each column, and each block of the current band.

Test Plan:
- Canonical grid v(r,c) = ((3r + r/3 + c) mod 9)+1, start pulse -> done after 82 cycles, success=1, err_code=0, busy low after.
- Canonical with (0,0)=0 -> done after 2 cycles, success=0, err_code=1 (RANGE), err (0,0).
- Canonical with (4,7) set to v(4,2)=7 -> done after 45 cycles, err_code=2 (ROW), err (4,7).
- Canonical with (2,0),(2,3) swapped -> err_code=3 (COL) at (2,0) (value 1 already in col 0), done after 20 cycles.
- Canonical with whole columns 2 and 3 swapped -> rows/cols legal; err_code=4 (BLOCK) at (1,0) (value 4), done after 11 cycles.
- Control/reset:
  - Start pulse during SCAN ignored.
  - reset low at cycle 40 -> busy=done=0 asynchronously.
  - Fresh start -> full 82-cycle pass on the canonical grid.
  - Second start while done -> done clears the next cycle and the pass repeats.

Source files
------------

// File: rtl/grid_pkg.sv
// Shared definitions for the grid verifier: grid geometry, value/index
// types, error classes, FSM states and the block-index helper.
package grid_pkg;

   localparam int ORDER     = 3;
   localparam int LENGTH    = ORDER * ORDER;
   localparam int AREA      = LENGTH * LENGTH;
   localparam int LAST_CELL = AREA - 1;

   localparam int VALUE_W = $clog2(LENGTH + 1);
   localparam int INDEX_W = $clog2(LENGTH);
   localparam int BAND_W  = (ORDER > 1) ? $clog2(ORDER) : 1;

   typedef logic [VALUE_W-1:0] value_t;
   typedef logic [INDEX_W-1:0] index_t;
   typedef logic [BAND_W-1:0]  band_t;

   typedef enum logic [2:0] {
      ERR_NONE  = 3'd0,
      ERR_RANGE = 3'd1,
      ERR_ROW   = 3'd2,
      ERR_COL   = 3'd3,
      ERR_BLOCK = 3'd4
   } err_code_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DRAIN,
      ST_DONE
   } state_e;

   // Block number (0..LENGTH-1, row-major over blocks) containing a cell.
   function automatic index_t block_of(input index_t row, input index_t col);
      return index_t'((int'(row) / ORDER) * ORDER + int'(col) / ORDER);
   endfunction

endpackage

// File: rtl/unit_mask.sv
// One LENGTH-bit occupancy set. 'hit' reports whether 'value' is already
// present; 'clear' empties the set before this cycle's lookup and update,
// so a clear and a set in the same cycle leave exactly the new value.
module unit_mask
   import grid_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               clear,
   input  logic               set_en,
   input  logic [VALUE_W-1:0] value,
   output logic               hit
);

   logic [LENGTH-1:0] mask_reg;
   logic [LENGTH-1:0] onehot;

   // Decode a legal value (1..LENGTH) into its occupancy bit; others map to none.
   always_comb begin
      onehot = '0;
      if (value != '0 && value <= value_t'(LENGTH))
         onehot[value - value_t'(1)] = 1'b1;
   end

   assign hit = (|(mask_reg & onehot)) && !clear;

   // Occupancy register: optional clear, then optional insertion of the value.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         mask_reg <= '0;
      else
         mask_reg <= (clear ? '0 : mask_reg) | (set_en ? onehot : '0);
   end

endmodule

// File: rtl/grid_verifier.sv
// Grid verifier: scans a finished LENGTH x LENGTH grid in row-major order
// through a one-cycle-latency read port and checks range, row, column and
// block uniqueness, stopping at the first offending cell.
// Optional macro GRID_VERIFIER_ERR_LOC_EN adds err_row/err_col outputs
// carrying the location of the first offending cell.
module grid_verifier
   import grid_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   output logic               rd_en,
   output logic [INDEX_W-1:0] rd_row,
   output logic [INDEX_W-1:0] rd_col,
   input  logic [VALUE_W-1:0] rd_data,
   output logic               busy,
   output logic               done,
   output logic               success,
   output logic [2:0]         err_code
`ifdef GRID_VERIFIER_ERR_LOC_EN
   ,
   output logic [INDEX_W-1:0] err_row,
   output logic [INDEX_W-1:0] err_col
`endif
);

   state_e    state_reg, state_next;
   index_t    addr_row_reg, addr_col_reg;
   logic      chk_valid_reg;
   index_t    chk_row_reg, chk_col_reg;
   logic      success_reg;
   err_code_e err_code_reg;

   logic      start_accept;
   logic      addr_last;
   logic      last_check;
   logic      range_err;
   logic      row_hit, col_hit, blk_hit;
   logic [LENGTH-1:0] col_hit_vec;
   logic [ORDER-1:0]  blk_hit_vec;
   band_t     band_blk;
   logic      row_clear, band_clear;
   err_code_e cell_err;
   logic      err_found;
   logic      cell_ok;

   // start is only honoured when no scan is running (busy wins on a tie).
   assign start_accept = start && (state_reg == ST_IDLE || state_reg == ST_DONE);
   assign addr_last    = (addr_row_reg == index_t'(LENGTH - 1)) &&
                         (addr_col_reg == index_t'(LENGTH - 1));
   assign last_check   = chk_valid_reg &&
                         ((int'(chk_row_reg) * LENGTH + int'(chk_col_reg)) == LAST_CELL);

   // Masks of the current row and band restart with the first cell checked in them.
   assign row_clear  = start_accept || (chk_valid_reg && chk_col_reg == '0);
   assign band_clear = start_accept ||
                       (chk_valid_reg && chk_col_reg == '0 && (int'(chk_row_reg) % ORDER) == 0);
   assign band_blk   = band_t'(int'(block_of(chk_row_reg, chk_col_reg)) % ORDER);

   assign range_err = (rd_data == '0) || (rd_data > value_t'(LENGTH));
   assign col_hit   = col_hit_vec[chk_col_reg];
   assign blk_hit   = blk_hit_vec[band_blk];

   unit_mask u_row_mask (
      .clock  (clock),
      .reset  (reset),
      .clear  (row_clear),
      .set_en (cell_ok),
      .value  (rd_data),
      .hit    (row_hit)
   );

   genvar gi;
   generate
      for (gi = 0; gi < LENGTH; gi++) begin : g_col_mask
         unit_mask u_col_mask (
            .clock  (clock),
            .reset  (reset),
            .clear  (start_accept),
            .set_en (cell_ok && (chk_col_reg == index_t'(gi))),
            .value  (rd_data),
            .hit    (col_hit_vec[gi])
         );
      end
      for (gi = 0; gi < ORDER; gi++) begin : g_blk_mask
         unit_mask u_blk_mask (
            .clock  (clock),
            .reset  (reset),
            .clear  (band_clear),
            .set_en (cell_ok && (band_blk == band_t'(gi))),
            .value  (rd_data),
            .hit    (blk_hit_vec[gi])
         );
      end
   endgenerate

   // Classify the cell under check in priority order RANGE > ROW > COL > BLOCK.
   always_comb begin
      cell_err = ERR_NONE;
      if (range_err)
         cell_err = ERR_RANGE;
      else if (row_hit)
         cell_err = ERR_ROW;
      else if (col_hit)
         cell_err = ERR_COL;
      else if (blk_hit)
         cell_err = ERR_BLOCK;
   end

   assign err_found = chk_valid_reg && (cell_err != ERR_NONE);
   assign cell_ok   = chk_valid_reg && (cell_err == ERR_NONE);

   // FSM state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   // FSM next-state: scan addresses, drain the last read, stop on first error.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE, ST_DONE: if (start) state_next = ST_SCAN;
         ST_SCAN: begin
            if (err_found)
               state_next = ST_DONE;
            else if (addr_last)
               state_next = ST_DRAIN;
         end
         ST_DRAIN: if (err_found || last_check) state_next = ST_DONE;
         default: state_next = ST_IDLE;
      endcase
   end

   // FSM outputs decoded from the current state.
   always_comb begin
      rd_en = 1'b0;
      busy  = 1'b0;
      done  = 1'b0;
      case (state_reg)
         ST_SCAN:  begin rd_en = 1'b1; busy = 1'b1; end
         ST_DRAIN: busy = 1'b1;
         ST_DONE:  done = 1'b1;
         default:  ;
      endcase
   end

   // Read address counter: column-fastest walk, one cell per scan cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         addr_row_reg <= '0;
         addr_col_reg <= '0;
      end else if (start_accept) begin
         addr_row_reg <= '0;
         addr_col_reg <= '0;
      end else if (state_reg == ST_SCAN && !addr_last && !err_found) begin
         if (addr_col_reg == index_t'(LENGTH - 1)) begin
            addr_col_reg <= '0;
            addr_row_reg <= addr_row_reg + index_t'(1);
         end else begin
            addr_col_reg <= addr_col_reg + index_t'(1);
         end
      end
   end

   assign rd_row = addr_row_reg;
   assign rd_col = addr_col_reg;

   // Track which cell's data arrives next; an error discards the read in flight.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         chk_valid_reg <= 1'b0;
         chk_row_reg   <= '0;
         chk_col_reg   <= '0;
      end else begin
         chk_valid_reg <= rd_en && !err_found;
         chk_row_reg   <= addr_row_reg;
         chk_col_reg   <= addr_col_reg;
      end
   end

   // Result registers: cleared on accepted start, latched at the end of the scan.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         success_reg  <= 1'b0;
         err_code_reg <= ERR_NONE;
      end else if (start_accept) begin
         success_reg  <= 1'b0;
         err_code_reg <= ERR_NONE;
      end else if (err_found) begin
         success_reg  <= 1'b0;
         err_code_reg <= cell_err;
      end else if (last_check) begin
         success_reg  <= 1'b1;
      end
   end

   assign success  = success_reg;
   assign err_code = err_code_reg;

`ifdef GRID_VERIFIER_ERR_LOC_EN
   index_t err_row_reg, err_col_reg;

   // Location of the first offending cell; stays zero for a legal grid.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         err_row_reg <= '0;
         err_col_reg <= '0;
      end else if (start_accept) begin
         err_row_reg <= '0;
         err_col_reg <= '0;
      end else if (err_found) begin
         err_row_reg <= chk_row_reg;
         err_col_reg <= chk_col_reg;
      end
   end

   assign err_row = err_row_reg;
   assign err_col = err_col_reg;
`endif

endmodule

// File: tb/tb_grid_verifier.sv
// Testbench for grid_verifier: a synchronous grid memory feeds the DUT and a
// cell-by-cell reference model predicts completion latency, verdict and the
// first offending cell for directed and randomly transformed/corrupted grids.
module tb_grid_verifier;
   import grid_pkg::*;

   logic               clock;
   logic               reset;
   logic               start;
   logic               rd_en;
   logic [INDEX_W-1:0] rd_row;
   logic [INDEX_W-1:0] rd_col;
   logic [VALUE_W-1:0] rd_data;
   logic               busy;
   logic               done;
   logic               success;
   logic [2:0]         err_code;
`ifdef GRID_VERIFIER_ERR_LOC_EN
   logic [INDEX_W-1:0] err_row;
   logic [INDEX_W-1:0] err_col;
`endif

   logic [VALUE_W-1:0] g [LENGTH][LENGTH];
   int checks_total  = 0;
   int checks_passed = 0;

   grid_verifier dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .rd_en    (rd_en),
      .rd_row   (rd_row),
      .rd_col   (rd_col),
      .rd_data  (rd_data),
      .busy     (busy),
      .done     (done),
      .success  (success),
      .err_code (err_code)
`ifdef GRID_VERIFIER_ERR_LOC_EN
      ,
      .err_row  (err_row),
      .err_col  (err_col)
`endif
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Grid storage with one cycle of read latency.
   always @(posedge clock) begin
      if (rd_en)
         rd_data <= g[rd_row][rd_col];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_total++;
      assert (obs === exp) checks_passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   function automatic int canon(input int r, input int c);
      return ((3 * r + r / 3 + c) % 9) + 1;
   endfunction

   task automatic load_canonical();
      for (int r = 0; r < LENGTH; r++)
         for (int c = 0; c < LENGTH; c++)
            g[r][c] = VALUE_W'(canon(r, c));
   endtask

   // Legal grid from the canonical one by permuting bands, rows within bands,
   // stacks, columns within stacks and symbol labels; then maybe one corruption.
   task automatic build_random_grid();
      int bp[3];
      int ip[3];
      int rp[9];
      int cp[9];
      int vp[9];
      int t, j, rr, cc;
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 3; i++) bp[i] = i;
         for (int i = 2; i > 0; i--) begin
            j = int'($urandom_range(i, 0)); t = bp[i]; bp[i] = bp[j]; bp[j] = t;
         end
         for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 3; i++) ip[i] = i;
            for (int i = 2; i > 0; i--) begin
               j = int'($urandom_range(i, 0)); t = ip[i]; ip[i] = ip[j]; ip[j] = t;
            end
            for (int i = 0; i < 3; i++) begin
               if (pass == 0) rp[b * 3 + i] = bp[b] * 3 + ip[i];
               else           cp[b * 3 + i] = bp[b] * 3 + ip[i];
            end
         end
      end
      for (int i = 0; i < 9; i++) vp[i] = i;
      for (int i = 8; i > 0; i--) begin
         j = int'($urandom_range(i, 0)); t = vp[i]; vp[i] = vp[j]; vp[j] = t;
      end
      for (int r = 0; r < LENGTH; r++)
         for (int c = 0; c < LENGTH; c++)
            g[r][c] = VALUE_W'(vp[canon(rp[r], cp[c]) - 1] + 1);
      if ($urandom_range(3, 0) != 0) begin
         rr = int'($urandom_range(8, 0));
         cc = int'($urandom_range(8, 0));
         g[rr][cc] = VALUE_W'($urandom_range(15, 0));
      end
   endtask

   // Reference: walk cells row-major; the first cell that is out of range or
   // repeats a value already seen in its row, column or block decides the result.
   task automatic model_grid(output int lat, output int code, output int er, output int ec);
      int v;
      bit found;
      found = 0; lat = AREA + 1; code = 0; er = 0; ec = 0;
      for (int r = 0; r < LENGTH && !found; r++) begin
         for (int c = 0; c < LENGTH && !found; c++) begin
            v = int'(g[r][c]);
            code = 0;
            if (v < 1 || v > LENGTH) code = 1;
            if (code == 0)
               for (int c2 = 0; c2 < c; c2++) if (int'(g[r][c2]) == v) code = 2;
            if (code == 0)
               for (int r2 = 0; r2 < r; r2++) if (int'(g[r2][c]) == v) code = 3;
            if (code == 0)
               for (int r2 = (r / 3) * 3; r2 <= r; r2++)
                  for (int c2 = (c / 3) * 3; c2 < (c / 3) * 3 + 3; c2++)
                     if ((r2 < r || c2 < c) && int'(g[r2][c2]) == v) code = 4;
            if (code != 0) begin
               found = 1; lat = r * LENGTH + c + 2; er = r; ec = c;
            end
         end
      end
   endtask

   // One verification pass; 'poke' > 0 raises start before edge E0+poke.
   task automatic run_grid(input string tag, input int poke);
      int exp_lat, exp_code, exp_r, exp_c, lat;
      bit got;
      model_grid(exp_lat, exp_code, exp_r, exp_c);
      @(negedge clock); start = 1'b1;
      @(posedge clock); #1; start = 1'b0;
      chk({tag, ".busy_after_start"}, busy, 1);
      chk({tag, ".done_cleared"}, done, 0);
      chk({tag, ".first_addr"}, {rd_en, rd_row, rd_col}, {1'b1, {INDEX_W{1'b0}}, {INDEX_W{1'b0}}});
      lat = 0; got = 0;
      while (!got && lat < 200) begin
         if (poke > 0 && lat + 1 == poke) begin
            @(negedge clock); start = 1'b1;
         end
         @(posedge clock); #1; start = 1'b0;
         lat++;
         if (done) got = 1;
      end
      chk({tag, ".done_seen"}, got, 1);
      chk({tag, ".latency"}, lat, exp_lat);
      chk({tag, ".success"}, success, (exp_code == 0) ? 1 : 0);
      chk({tag, ".err_code"}, err_code, exp_code);
      chk({tag, ".busy_at_done"}, {busy, rd_en}, 0);
`ifdef GRID_VERIFIER_ERR_LOC_EN
      chk({tag, ".err_row"}, err_row, exp_r);
      chk({tag, ".err_col"}, err_col, exp_c);
`endif
      $display("run %s: latency %0d (model %0d) success %0d err_code %0d (model %0d) at (%0d,%0d)",
               tag, lat, exp_lat, success, err_code, exp_code, exp_r, exp_c);
      if (poke > 0 && poke == exp_lat) begin
         @(posedge clock); #1;
         chk({tag, ".start_on_final_edge_ignored"}, {done, busy}, 2'b10);
      end
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      load_canonical();
      #1;
      chk("reset.outputs", {rd_en, busy, done, success, err_code}, 0);
      @(negedge clock); reset = 1'b1;
      @(posedge clock); #1;
      chk("idle.after_reset", {busy, done}, 0);

      // Directed grids.
      load_canonical();
      run_grid("canonical", 0);
      load_canonical(); g[0][0] = '0;
      run_grid("range_00", 0);
      load_canonical(); g[4][7] = VALUE_W'(canon(4, 2));
      run_grid("row_47", 0);
      load_canonical(); g[2][0] = VALUE_W'(canon(2, 3)); g[2][3] = VALUE_W'(canon(2, 0));
      run_grid("col_20", 0);
      load_canonical();
      for (int r = 0; r < LENGTH; r++) begin
         g[r][2] = VALUE_W'(canon(r, 3));
         g[r][3] = VALUE_W'(canon(r, 2));
      end
      run_grid("block_10", 0);

      // Start during SCAN is ignored: completion time unchanged.
      load_canonical();
      run_grid("poke_scan", 30);

      // Asynchronous reset mid-scan.
      @(negedge clock); start = 1'b1;
      @(posedge clock); #1; start = 1'b0;
      repeat (40) @(posedge clock);
      #2; reset = 1'b0;
      #1;
      chk("async_reset.busy_done", {busy, done, rd_en}, 0);
      @(negedge clock); reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("after_reset.idle", {busy, done, success}, 0);
      $display("run async_reset: busy %0d done %0d", busy, done);

      // Fresh start, then restart from DONE, then start on the final check edge.
      run_grid("fresh", 0);
      chk("done_held_before_restart", done, 1);
      run_grid("restart", 0);
      run_grid("coincident_start", AREA + 1);

      // Randomized grids.
      for (int n = 0; n < 10; n++) begin
         build_random_grid();
         run_grid($sformatf("random%0d", n), 0);
      end

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
